// File: rtl/cdc_reg_responder_pkg.sv
// Shared constants and types for the CDC lane register responder:
// register offsets, CTRL/STATUS bit positions and the multiply FSM state type.
package cdc_reg_responder_pkg;

    // Byte offsets inside the 6-word window, compared against {address[4:2], 2'b00}.
    localparam logic [4:0] CDC_RESP_CTRL    = 5'h00;
    localparam logic [4:0] CDC_RESP_STATUS  = 5'h04;
    localparam logic [4:0] CDC_RESP_OPA     = 5'h08;
    localparam logic [4:0] CDC_RESP_OPB     = 5'h0C;
    localparam logic [4:0] CDC_RESP_RESULT  = 5'h10;
    localparam logic [4:0] CDC_RESP_SCRATCH = 5'h14;

    localparam int unsigned CTRL_START     = 0;
    localparam int unsigned CTRL_CLR_DONE  = 1;
    localparam int unsigned CTRL_CLR_ERR   = 2;

    localparam int unsigned STATUS_BUSY    = 0;
    localparam int unsigned STATUS_DONE    = 1;
    localparam int unsigned STATUS_ERR     = 2;
    localparam int unsigned STATUS_REJ_LSB = 8;
    localparam int unsigned STATUS_REJ_MSB = 15;

    typedef enum logic [1:0] {
        CDC_RESP_IDLE   = 2'd0,
        CDC_RESP_RUN    = 2'd1,
        CDC_RESP_FINISH = 2'd2
    } cdc_resp_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/cdc_reg_responder_if.sv
// Register-bus bundle between one CDC lane and its responder.
interface cdc_reg_responder_if #(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 32
);
    logic [address_width-1:0] address_i;
    logic [data_width-1:0]    data_i;
    logic                     we_i;
    logic                     we_ram_i;
    logic [data_width-1:0]    data_o;
    logic                     module_busy_o;

    modport master (
        output address_i, data_i, we_i, we_ram_i,
        input  data_o, module_busy_o
    );

    modport slave (
        input  address_i, data_i, we_i, we_ram_i,
        output data_o, module_busy_o
    );
endinterface

// File: rtl/cdc_resp_mul_engine.sv
// Iterative shift/add multiplier: one RUN cycle per operand bit, then a
// single FINISH cycle that publishes the truncated product.
module cdc_resp_mul_engine
    import cdc_reg_responder_pkg::*;
#(
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [data_width-1:0] opa,
    input  logic [data_width-1:0] opb,
    output cdc_resp_state_t       state,
    output logic                  busy,
    output logic                  finish,
    output logic [data_width-1:0] result
);
    localparam int unsigned cnt_w = $clog2(data_width);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(data_width - 1);

    cdc_resp_state_t       state_r;
    logic [data_width-1:0] mcand_r;
    logic [data_width-1:0] mplier_r;
    logic [data_width-1:0] acc_r;
    logic [data_width-1:0] result_r;
    logic [cnt_w-1:0]      cnt_r;
    logic                  busy_r;

    // Multiply FSM with its shift/add datapath and bit counter.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r  <= CDC_RESP_IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            result_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                CDC_RESP_IDLE: begin
                    if (start) begin
                        mcand_r  <= opa;
                        mplier_r <= opb;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= CDC_RESP_RUN;
                    end
                end
                CDC_RESP_RUN: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[data_width-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[data_width-1:1]};
                    cnt_r    <= cnt_r + cnt_w'(1);
                    if (cnt_r == cnt_last) begin
                        state_r <= CDC_RESP_FINISH;
                    end
                end
                CDC_RESP_FINISH: begin
                    result_r <= acc_r;
                    busy_r   <= 1'b0;
                    state_r  <= CDC_RESP_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= CDC_RESP_IDLE;
                end
            endcase
        end
    end

    assign state  = state_r;
    assign busy   = busy_r;
    assign result = result_r;
    assign finish = (state_r == CDC_RESP_FINISH);

endmodule

// File: rtl/cdc_reg_responder.sv
// CDC lane endpoint: window decode, register file and OR-bus read mux
// around the iterative multiply engine.
module cdc_reg_responder
    import cdc_reg_responder_pkg::*;
#(
    parameter int unsigned              address_width = 32,
    parameter int unsigned              data_width    = 32,
    parameter logic [address_width-1:0] base_address  = 32'h0000_9000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cpu_reset_i,
    cdc_reg_responder_if.slave bus
);
    logic                  srst_s;
    logic                  hit_s;
    logic [4:0]            offset_s;
    logic                  wr_s;
    logic                  wr_ctrl_s, wr_opa_s, wr_opb_s, wr_scratch_s;
    logic                  start_req_s, start_ok_s, reject_s;
    logic                  clr_done_s, clr_err_s;
    logic                  idle_s, busy_s, finish_s;
    cdc_resp_state_t       eng_state_s;
    logic [data_width-1:0] result_s;
    logic [data_width-1:0] status_s;
    logic [data_width-1:0] rdata_s;
    logic                  unused_s;

    logic [data_width-1:0] opa_r, opb_r, scratch_r, data_o_r;
    logic                  done_r, err_r;
    logic [7:0]            rej_cnt_r;

    assign srst_s   = ~reset_i | cpu_reset_i;
    assign unused_s = bus.we_ram_i;
    assign offset_s = {bus.address_i[4:2], 2'b00};
    assign hit_s    = (bus.address_i >= base_address) &&
                      (bus.address_i <= (base_address + address_width'(32'h17)));

    assign wr_s         = bus.we_i & hit_s;
    assign wr_ctrl_s    = wr_s && (offset_s == CDC_RESP_CTRL);
    assign wr_opa_s     = wr_s && (offset_s == CDC_RESP_OPA);
    assign wr_opb_s     = wr_s && (offset_s == CDC_RESP_OPB);
    assign wr_scratch_s = wr_s && (offset_s == CDC_RESP_SCRATCH);
    assign start_req_s  = wr_ctrl_s & bus.data_i[CTRL_START];
    assign clr_done_s   = wr_ctrl_s & bus.data_i[CTRL_CLR_DONE];
    assign clr_err_s    = wr_ctrl_s & bus.data_i[CTRL_CLR_ERR];
    assign idle_s       = (eng_state_s == CDC_RESP_IDLE);
    assign start_ok_s   = start_req_s & idle_s;
    // Operand and start writes would corrupt a running operation, so they bounce.
    assign reject_s     = ~idle_s & (start_req_s | wr_opa_s | wr_opb_s);

    cdc_resp_mul_engine #(.data_width(data_width)) u_engine (
        .clk    (clk_i),
        .srst   (srst_s),
        .start  (start_ok_s),
        .opa    (opa_r),
        .opb    (opb_r),
        .state  (eng_state_s),
        .busy   (busy_s),
        .finish (finish_s),
        .result (result_s)
    );

    // STATUS word assembly.
    always_comb begin
        status_s = '0;
        status_s[STATUS_BUSY] = busy_s;
        status_s[STATUS_DONE] = done_r;
        status_s[STATUS_ERR]  = err_r;
        status_s[STATUS_REJ_MSB:STATUS_REJ_LSB] = rej_cnt_r;
    end

    // Read mux; CTRL and anything outside the window read as zero.
    always_comb begin
        rdata_s = '0;
        if (hit_s) begin
            case (offset_s)
                CDC_RESP_STATUS:  rdata_s = status_s;
                CDC_RESP_OPA:     rdata_s = opa_r;
                CDC_RESP_OPB:     rdata_s = opb_r;
                CDC_RESP_RESULT:  rdata_s = result_s;
                CDC_RESP_SCRATCH: rdata_s = scratch_r;
                default:          rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    // Register file, sticky flags, reject counter and registered read data.
    always_ff @(posedge clk_i) begin
        if (srst_s) begin
            opa_r     <= '0;
            opb_r     <= '0;
            scratch_r <= '0;
            data_o_r  <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rej_cnt_r <= 8'd0;
        end else begin
            data_o_r <= rdata_s;
            if (wr_opa_s && idle_s) begin
                opa_r <= bus.data_i;
            end
            if (wr_opb_s && idle_s) begin
                opb_r <= bus.data_i;
            end
            if (wr_scratch_s) begin
                scratch_r <= bus.data_i;
            end
            if (finish_s) begin
                done_r <= 1'b1;
            end else if (clr_done_s) begin
                done_r <= 1'b0;
            end
            if (reject_s) begin
                err_r     <= 1'b1;
                rej_cnt_r <= sat_inc8(rej_cnt_r);
            end else if (clr_err_s) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.data_o        = data_o_r;
    assign bus.module_busy_o = busy_s;

endmodule

// File: tb/tb_cdc_reg_responder.sv
// Directed bench for cdc_reg_responder: a register-access vector table plus
// hand-written multiply, rejection, abort and set/clear race sequences.
module tb_cdc_reg_responder;

    localparam logic [31:0] BASE    = 32'h0000_9000;
    localparam logic [31:0] A_CTRL  = BASE + 32'h00;
    localparam logic [31:0] A_STAT  = BASE + 32'h04;
    localparam logic [31:0] A_OPA   = BASE + 32'h08;
    localparam logic [31:0] A_OPB   = BASE + 32'h0C;
    localparam logic [31:0] A_RES   = BASE + 32'h10;
    localparam logic [31:0] A_SCR   = BASE + 32'h14;

    logic clk = 1'b0;
    logic reset_i;
    logic cpu_reset_i;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs[$];

    cdc_reg_responder_if bus_if ();

    cdc_reg_responder #(
        .address_width (32),
        .data_width    (32),
        .base_address  (BASE)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .cpu_reset_i (cpu_reset_i),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.address_i = addr;
        bus_if.data_i    = data;
        bus_if.we_i      = 1'b1;
        @(negedge clk);
        bus_if.we_i      = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_if.address_i = addr;
        bus_if.we_i      = 1'b0;
        @(negedge clk);
        data = bus_if.data_o;
    endtask

    task automatic check_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_read(addr, d);
        check(name, d, exp);
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus_if.module_busy_o === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 100) begin
            check("busy_timeout", {31'd0, bus_if.module_busy_o}, 32'd0);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] d;

        reset_i          = 1'b0;
        cpu_reset_i      = 1'b0;
        bus_if.address_i = 32'h0;
        bus_if.data_i    = 32'h0;
        bus_if.we_i      = 1'b0;
        bus_if.we_ram_i  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_in_reset", {31'd0, bus_if.module_busy_o}, 32'd0);
        reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_read(BASE + 32'(i * 4), 32'h0, $sformatf("reset_rd_%0d", i));
        end
        check("busy_after_reset", {31'd0, bus_if.module_busy_o}, 32'd0);

        // Register access table: writes then reads with expected data.
        add_vec(1'b1, A_OPA,          32'h0000_1234, "wr_opa");
        add_vec(1'b0, A_OPA,          32'h0000_1234, "rd_opa");
        add_vec(1'b1, A_SCR,          32'hDEAD_BEEF, "wr_scratch");
        add_vec(1'b0, A_SCR,          32'hDEAD_BEEF, "rd_scratch");
        add_vec(1'b0, BASE + 32'h18,  32'h0,         "rd_past_window");
        add_vec(1'b1, A_OPB,          32'h5555_AAAA, "wr_opb");
        add_vec(1'b0, A_OPB,          32'h5555_AAAA, "rd_opb");
        add_vec(1'b0, BASE + 32'h0F,  32'h5555_AAAA, "rd_opb_bytelane");
        add_vec(1'b0, A_CTRL,         32'h0,         "rd_ctrl_wo");
        add_vec(1'b0, BASE - 32'h18,  32'h0,         "rd_below_alias");
        add_vec(1'b0, BASE + 32'h28,  32'h0,         "rd_above_alias");
        add_vec(1'b1, BASE + 32'h34,  32'hFFFF_FFFF, "wr_outside");
        add_vec(1'b0, A_SCR,          32'hDEAD_BEEF, "rd_scratch_kept");
        add_vec(1'b1, A_STAT,         32'hFFFF_FFFF, "wr_status_ro");
        add_vec(1'b0, A_STAT,         32'h0,         "rd_status_ro");
        add_vec(1'b1, A_RES,          32'h1234_5678, "wr_result_ro");
        add_vec(1'b0, A_RES,          32'h0,         "rd_result_ro");
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                check_read(vecs[i].addr, vecs[i].data, vecs[i].name);
            end
        end

        // Multiply with wrap-around; busy window is 33 cycles.
        bus_write(A_OPA, 32'h0001_0003);
        bus_write(A_OPB, 32'h0002_0005);
        bus_write(A_CTRL, 32'h1);
        wait_idle(cyc);
        check("busy_cycles", 32'(cyc), 32'd33);
        check_read(A_RES,  32'h000B_000F, "mul1_result");
        check_read(A_STAT, 32'h0000_0002, "mul1_status");
        check_read(A_OPA,  32'h0001_0003, "opa_kept");

        // Truncation, with start+clear_done in the same write.
        bus_write(A_OPA, 32'hFFFF_FFFF);
        bus_write(A_OPB, 32'h0000_0002);
        bus_write(A_CTRL, 32'h3);
        check_read(A_STAT, 32'h0000_0001, "start_clr_done_status");
        wait_idle(cyc);
        check_read(A_RES,  32'hFFFF_FFFE, "mul2_result");
        check_read(A_STAT, 32'h0000_0002, "mul2_status");

        // Busy rejection
        bus_write(A_OPA, 32'h0001_0003);
        bus_write(A_OPB, 32'h0002_0005);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_OPA, 32'h0000_0007);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_SCR, 32'h0BAD_F00D);
        check_read(A_OPA,  32'h0001_0003, "opa_rejected");
        check_read(A_STAT, 32'h0000_0207, "reject_status");
        wait_idle(cyc);
        check_read(A_RES,  32'h000B_000F, "reject_result");
        check_read(A_SCR,  32'h0BAD_F00D, "scratch_while_busy");
        bus_write(A_CTRL, 32'h4);
        check_read(A_STAT, 32'h0000_0202, "clear_err_status");

        // clear_done landing on the FINISH edge: set wins.
        bus_write(A_CTRL, 32'h1);
        repeat (31) @(negedge clk);
        check("race_busy_before", {31'd0, bus_if.module_busy_o}, 32'd1);
        bus_write(A_CTRL, 32'h2);
        check("race_busy_after", {31'd0, bus_if.module_busy_o}, 32'd0);
        check_read(A_STAT, 32'h0000_0202, "race_done_kept");
        bus_write(A_CTRL, 32'h2);
        check_read(A_STAT, 32'h0000_0200, "later_clear_done");

        // Abort via cpu_reset_i while cnt == 10.
        bus_write(A_CTRL, 32'h1);
        repeat (9) @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, bus_if.module_busy_o}, 32'd1);
        cpu_reset_i = 1'b1;
        @(negedge clk);
        cpu_reset_i = 1'b0;
        check("abort_busy_after", {31'd0, bus_if.module_busy_o}, 32'd0);
        check_read(A_RES,  32'h0, "abort_result");
        check_read(A_STAT, 32'h0, "abort_status");
        check_read(A_OPA,  32'h0, "abort_opa");
        bus_write(A_OPA, 32'h0000_0003);
        bus_write(A_OPB, 32'h0000_0005);
        bus_write(A_CTRL, 32'h1);
        wait_idle(cyc);
        check("rerun_busy_cycles", 32'(cyc), 32'd33);
        check_read(A_RES,  32'h0000_000F, "rerun_result");
        check_read(A_STAT, 32'h0000_0002, "rerun_status");

        // Reject counter saturation: 20 runs x 14 rejected writes.
        for (int r = 0; r < 20; r++) begin
            bus_write(A_CTRL, 32'h1);
            for (int k = 0; k < 14; k++) begin
                bus_write(A_OPB, 32'h0000_0009);
            end
            wait_idle(cyc);
        end
        check_read(A_STAT, 32'h0000_FF06, "reject_saturated");
        check_read(A_OPB,  32'h0000_0005, "opb_after_rejects");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_reg_responder.md
Name: cdc_reg_responder

Overview:
- Peripheral-side endpoint for one lane of the CPU bus clock-domain crossing. It runs entirely in the lane's destination clock.
- Decodes the lane's address window and serves single-cycle register reads and writes.
- Contains a 32-cycle iterative multiply engine. While the engine runs, the block raises module_busy_o so the crossing logic can halt the CPU.
- Instantiated once per lane whose module_busy_en_mask bit is set.

Parameters:
- base_address, 32'h0000_9000, word-aligned start of the 6-word window.
- data_width, 32, bus data width; also the operand width.
- address_width, 32, bus address width.

Ports:
- clk_i  input  1  lane clock.
- reset_i  input  1  synchronous, active-low reset.
- cpu_reset_i  input  1  synchronous, active-high soft reset from the CPU side; same effect as reset_i.
- address_i  input  address_width  bus address, held by the crossing logic for a whole transaction.
- data_i  input  data_width  write data.
- we_i  input  1  one-cycle write strobe.
- we_ram_i  input  1  RAM write strobe; ignored by this block.
- data_o  output  data_width  registered read data; OR-bus style, so 0 when not selected.
- module_busy_o  output  1  high while the multiply engine is running.

Behaviour:
- Register map (byte offset from base_address):
  - 0x00 CTRL, write-only. Bit0 = start, bit1 = clear_done, bit2 = clear_err. All bits self-clear.
  - 0x04 STATUS, read-only. Bit0 = busy, bit1 = done (sticky), bit2 = err (sticky), bits[15:8] = count of rejected writes (saturates at 255).
  - 0x08 OPA, read/write.
  - 0x0C OPB, read/write.
  - 0x10 RESULT, read-only. Low data_width bits of OPA*OPB.
  - 0x14 SCRATCH, read/write; no side effects.
- Address decode:
  - hit = address_i in [base_address, base_address+0x17].
  - Register index = address_i[4:2]; bits[1:0] are ignored.
- Reads: data_o <= selected register on every clock, giving a latency of 1 cycle. When hit is false, or the offset is 0x00, data_o <= 0.
- Writes act only when we_i & hit.
- Reset (either reset_i==0 or cpu_reset_i==1):
  - All registers, counters and outputs go to 0; data_o=0, module_busy_o=0; FSM goes to IDLE.
  - Reset aborts any running operation. No done flag is set.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on a CTRL write with bit0=1:
    - Latch the multiplicand from OPA and the multiplier from OPB.
    - Clear the accumulator; cnt <= 0.
    - module_busy_o <= 1, effective the next cycle.
  - RUN, each cycle:
    - If multiplier[0], acc <= acc + multiplicand (truncated to data_width).
    - multiplicand <<= 1; multiplier >>= 1; cnt++.
    - RUN -> FINISH after cnt == data_width-1, i.e. after data_width RUN cycles.
  - FINISH (one cycle): RESULT <= acc; done <= 1; module_busy_o <= 0; -> IDLE.
  - Latency: start write in cycle N gives busy high in N+1..N+data_width+1, busy low in N+data_width+2, and RESULT readable from the read issued in N+data_width+2.
- Writes while busy:
  - Writes to CTRL.start, OPA or OPB while the FSM is not IDLE are rejected: err <= 1 and the reject count increments (saturating).
  - SCRATCH writes and CTRL clear bits are always accepted.
- Simultaneous events:
  - clear_done in the same cycle as FINISH: done remains 1 (set wins).
  - start and clear_done in the same write while IDLE: done <= 0 and the operation starts.
- OPA/OPB keep their programmed values after an operation, so a rerun needs no reload.

Decomposition:
- cpu_reg_package gains:
  - Register offset constants: CDC_RESP_CTRL, CDC_RESP_STATUS, CDC_RESP_OPA, CDC_RESP_OPB, CDC_RESP_RESULT, CDC_RESP_SCRATCH.
  - CTRL/STATUS bit-index constants.
  - The FSM enum type cdc_resp_state_t.
- One sub-module, cdc_resp_mul_engine, holds the FSM, shift/add datapath and counter. The top level keeps decode, register file and read mux.

Test Plan:
- Reset check: hold reset_i=0 for 3 cycles, then read every offset -> all read 0, module_busy_o=0.
- Register access: write OPA=0x0000_1234, SCRATCH=0xDEAD_BEEF; read back the next cycle -> data_o matches with 1-cycle latency. Read base_address+0x18 -> 0.
- Multiply with wrap-around:
  - OPA=0x0001_0003, OPB=0x0002_0005, start -> busy high for exactly 33 cycles, then RESULT=0x000B_000F and STATUS=0x0000_0002.
  - OPA=0xFFFF_FFFF, OPB=2 -> RESULT=0xFFFF_FFFE (truncation).
- Busy rejection: during RUN, write OPA=7 and start=1 -> OPA unchanged, STATUS bit2=1, STATUS[15:8]=2, operation result unaffected. Then write clear_err -> bit2=0, count kept.
- Abort mid-operation: pulse cpu_reset_i at cnt=10 -> next cycle busy=0, RESULT=0, done=0, OPA=0. A new start after that completes normally.
- Set/clear race: write clear_done exactly in the FINISH cycle -> done reads 1. A later clear_done -> 0.
